// File: rtl/execute_mul_unit_if.sv
// Shared packet types and the issue/writeback/feedback bundle of the multiply execute unit.
// The package comes first so the interface and the unit can both import it.
package execute_mul_pkg;
  localparam int PHY_REG_ID_WIDTH    = 6;
  localparam int ROB_ID_WIDTH        = 5;
  localparam int CHECKPOINT_ID_WIDTH = 3;

  typedef enum logic [1:0] {
    MUL_MUL    = 2'd0,
    MUL_MULH   = 2'd1,
    MUL_MULHSU = 2'd2,
    MUL_MULHU  = 2'd3
  } mul_op_t;

  typedef struct packed {
    mul_op_t mul_op;
  } sub_op_t;

  typedef struct packed {
    logic                           enable;
    logic [31:0]                    value;
    logic                           valid;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic [31:0]                    pc;
    logic [31:0]                    imm;
    logic                           has_exception;
    logic [3:0]                     exception_id;
    logic [31:0]                    exception_value;
    logic                           predicted;
    logic                           predicted_jump;
    logic [31:0]                    predicted_next_pc;
    logic                           checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
    logic [4:0]                     rs1;
    logic [1:0]                     arg1_src;
    logic                           rs1_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
    logic [31:0]                    src1_value;
    logic                           src1_loaded;
    logic [4:0]                     rs2;
    logic [1:0]                     arg2_src;
    logic                           rs2_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
    logic [31:0]                    src2_value;
    logic                           src2_loaded;
    logic [4:0]                     rd;
    logic                           rd_enable;
    logic                           need_rename;
    logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
    logic [11:0]                    csr;
    logic [3:0]                     op;
    logic [2:0]                     op_unit;
    sub_op_t                        sub_op;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                           enable;
    logic [31:0]                    value;
    logic                           valid;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic [31:0]                    pc;
    logic [31:0]                    imm;
    logic                           has_exception;
    logic [3:0]                     exception_id;
    logic [31:0]                    exception_value;
    logic                           predicted;
    logic                           predicted_jump;
    logic [31:0]                    predicted_next_pc;
    logic                           checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
    logic                           bru_jump;
    logic [31:0]                    bru_next_pc;
    logic [4:0]                     rs1;
    logic [1:0]                     arg1_src;
    logic                           rs1_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
    logic [31:0]                    src1_value;
    logic                           src1_loaded;
    logic [4:0]                     rs2;
    logic [1:0]                     arg2_src;
    logic                           rs2_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
    logic [31:0]                    src2_value;
    logic                           src2_loaded;
    logic [4:0]                     rd;
    logic                           rd_enable;
    logic                           need_rename;
    logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
    logic [31:0]                    rd_value;
    logic [11:0]                    csr;
    logic                           csr_newvalue_valid;
    logic [31:0]                    csr_newvalue;
    logic [3:0]                     op;
    logic [2:0]                     op_unit;
    sub_op_t                        sub_op;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                        enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [31:0]                 value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;
endpackage

interface execute_mul_unit_if;
  import execute_mul_pkg::*;

  issue_execute_pack_t       issue_mul_fifo_data_out;
  logic                      issue_mul_fifo_data_out_valid;
  logic                      issue_mul_fifo_pop;
  execute_wb_pack_t          mul_wb_port_data_in;
  logic                      mul_wb_port_we;
  logic                      mul_wb_port_flush;
  execute_feedback_channel_t mul_execute_channel_feedback_pack;
  commit_feedback_pack_t     commit_feedback_pack;

  // master is the execute unit's view; slave is the surrounding core.
  modport master (
    input  issue_mul_fifo_data_out, issue_mul_fifo_data_out_valid, commit_feedback_pack,
    output issue_mul_fifo_pop, mul_wb_port_data_in, mul_wb_port_we, mul_wb_port_flush,
           mul_execute_channel_feedback_pack
  );

  modport slave (
    output issue_mul_fifo_data_out, issue_mul_fifo_data_out_valid, commit_feedback_pack,
    input  issue_mul_fifo_pop, mul_wb_port_data_in, mul_wb_port_we, mul_wb_port_flush,
           mul_execute_channel_feedback_pack
  );
endinterface

// File: rtl/execute_mul_unit.sv
// Single-cycle RV32M multiply execute unit: pops the issue FIFO head, writes back the
// product and broadcasts it on the feedback channel in the same cycle.
module execute_mul_unit
  import execute_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  execute_mul_unit_if.master io
);
  localparam int DATA_W = 32;

  // 33x33 signed multiply; the sign bit of each operand is chosen by the op variant.
  function automatic logic [DATA_W-1:0] mul_result(input mul_op_t op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0]     a_ext;
    logic signed [DATA_W:0]     b_ext;
    logic signed [2*DATA_W-1:0] prod;
    a_ext = {((op == MUL_MULH) || (op == MUL_MULHSU)) & a[DATA_W-1], a};
    b_ext = {(op == MUL_MULH) & b[DATA_W-1], b};
    prod  = (2*DATA_W)'(a_ext) * (2*DATA_W)'(b_ext);
    return (op == MUL_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  endfunction

  logic                rst_q;
  logic                run;
  logic                flush;
  logic                go;
  logic                rd_ok;
  logic [DATA_W-1:0]   rd_value;
  issue_execute_pack_t in_pack;
  execute_wb_pack_t    wb;
  execute_feedback_channel_t fb;

  // Outputs stay quiet until reset has been seen released at a clock edge.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign in_pack  = io.issue_mul_fifo_data_out;
  assign run      = rst & rst_q;
  assign flush    = io.commit_feedback_pack.enable & io.commit_feedback_pack.flush;
  assign go       = run & io.issue_mul_fifo_data_out_valid & ~flush;
  assign rd_ok    = in_pack.enable & in_pack.valid & ~in_pack.has_exception;
  assign rd_value = rd_ok ? mul_result(in_pack.sub_op.mul_op, in_pack.src1_value,
                                       in_pack.src2_value) : '0;

  assign io.issue_mul_fifo_pop  = go;
  assign io.mul_wb_port_we      = go;
  assign io.mul_wb_port_flush   = run & flush;
  assign io.mul_wb_port_data_in = wb;
  assign io.mul_execute_channel_feedback_pack = fb;

  always_comb begin
    wb = '0;
    if (go) begin
      wb.enable              = in_pack.enable;
      wb.value               = in_pack.value;
      wb.valid               = in_pack.valid;
      wb.rob_id              = in_pack.rob_id;
      wb.pc                  = in_pack.pc;
      wb.imm                 = in_pack.imm;
      wb.has_exception       = in_pack.has_exception;
      wb.exception_id        = in_pack.exception_id;
      wb.exception_value     = in_pack.exception_value;
      wb.predicted           = in_pack.predicted;
      wb.predicted_jump      = in_pack.predicted_jump;
      wb.predicted_next_pc   = in_pack.predicted_next_pc;
      wb.checkpoint_id_valid = in_pack.checkpoint_id_valid;
      wb.checkpoint_id       = in_pack.checkpoint_id;
      wb.rs1                 = in_pack.rs1;
      wb.arg1_src            = in_pack.arg1_src;
      wb.rs1_need_map        = in_pack.rs1_need_map;
      wb.rs1_phy             = in_pack.rs1_phy;
      wb.src1_value          = in_pack.src1_value;
      wb.src1_loaded         = in_pack.src1_loaded;
      wb.rs2                 = in_pack.rs2;
      wb.arg2_src            = in_pack.arg2_src;
      wb.rs2_need_map        = in_pack.rs2_need_map;
      wb.rs2_phy             = in_pack.rs2_phy;
      wb.src2_value          = in_pack.src2_value;
      wb.src2_loaded         = in_pack.src2_loaded;
      wb.rd                  = in_pack.rd;
      wb.rd_enable           = in_pack.rd_enable;
      wb.need_rename         = in_pack.need_rename;
      wb.rd_phy              = in_pack.rd_phy;
      wb.rd_value            = rd_value;
      wb.csr                 = in_pack.csr;
      wb.op                  = in_pack.op;
      wb.op_unit             = in_pack.op_unit;
      wb.sub_op              = in_pack.sub_op;
    end
  end

  // Only renamed destinations of clean, valid instructions wake up dependents.
  always_comb begin
    fb = '0;
    if (go & rd_ok & in_pack.rd_enable & in_pack.need_rename) begin
      fb.enable = 1'b1;
      fb.phy_id = in_pack.rd_phy;
      fb.value  = rd_value;
    end
  end
endmodule

// File: tb/tb_execute_mul_unit.sv
// Bench for execute_mul_unit: directed scenarios plus a random back-to-back stream,
// with expected outputs queued on drive and popped when the outputs settle.
module tb_execute_mul_unit;
  import execute_mul_pkg::*;

  typedef struct packed {
    logic                      pop;
    logic                      we;
    logic                      flush;
    execute_wb_pack_t          wb;
    execute_feedback_channel_t fb;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  execute_mul_unit_if io();

  execute_mul_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input issue_execute_pack_t in, input logic vld,
                                 input commit_feedback_pack_t c, input logic run);
    exp_t        e;
    logic        fl;
    logic        go;
    logic        ok;
    logic [63:0] sa;
    logic [63:0] sb_ext;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    logic [31:0] rv;
    e      = '0;
    fl     = c.enable & c.flush;
    go     = run & vld & ~fl;
    ok     = in.enable & in.valid & ~in.has_exception;
    sa     = {{32{in.src1_value[31]}}, in.src1_value};
    sb_ext = {{32{in.src2_value[31]}}, in.src2_value};
    ua     = {32'b0, in.src1_value};
    ub     = {32'b0, in.src2_value};
    case (in.sub_op.mul_op)
      MUL_MUL:    begin p = ua * ub;     rv = p[31:0];  end
      MUL_MULH:   begin p = sa * sb_ext; rv = p[63:32]; end
      MUL_MULHSU: begin p = sa * ub;     rv = p[63:32]; end
      default:    begin p = ua * ub;     rv = p[63:32]; end
    endcase
    if (!ok) rv = '0;
    e.pop   = go;
    e.we    = go;
    e.flush = run & fl;
    if (go) begin
      e.wb.enable = in.enable; e.wb.value = in.value; e.wb.valid = in.valid;
      e.wb.rob_id = in.rob_id; e.wb.pc = in.pc; e.wb.imm = in.imm;
      e.wb.has_exception = in.has_exception; e.wb.exception_id = in.exception_id;
      e.wb.exception_value = in.exception_value; e.wb.predicted = in.predicted;
      e.wb.predicted_jump = in.predicted_jump; e.wb.predicted_next_pc = in.predicted_next_pc;
      e.wb.checkpoint_id_valid = in.checkpoint_id_valid; e.wb.checkpoint_id = in.checkpoint_id;
      e.wb.rs1 = in.rs1; e.wb.arg1_src = in.arg1_src; e.wb.rs1_need_map = in.rs1_need_map;
      e.wb.rs1_phy = in.rs1_phy; e.wb.src1_value = in.src1_value; e.wb.src1_loaded = in.src1_loaded;
      e.wb.rs2 = in.rs2; e.wb.arg2_src = in.arg2_src; e.wb.rs2_need_map = in.rs2_need_map;
      e.wb.rs2_phy = in.rs2_phy; e.wb.src2_value = in.src2_value; e.wb.src2_loaded = in.src2_loaded;
      e.wb.rd = in.rd; e.wb.rd_enable = in.rd_enable; e.wb.need_rename = in.need_rename;
      e.wb.rd_phy = in.rd_phy; e.wb.rd_value = rv; e.wb.csr = in.csr;
      e.wb.op = in.op; e.wb.op_unit = in.op_unit; e.wb.sub_op = in.sub_op;
    end
    if (go & ok & in.rd_enable & in.need_rename) begin
      e.fb.enable = 1'b1;
      e.fb.phy_id = in.rd_phy;
      e.fb.value  = rv;
    end
    return e;
  endfunction

  function automatic issue_execute_pack_t mk(input mul_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
    issue_execute_pack_t p;
    p = '0;
    p.enable = 1'b1; p.valid = 1'b1; p.value = 32'h02b50533; p.rob_id = 5'd3;
    p.pc = 32'h8000_0100; p.imm = 32'h0000_0011; p.rs1 = 5'd10; p.rs2 = 5'd11;
    p.rs1_phy = 6'd12; p.rs2_phy = 6'd13; p.src1_loaded = 1'b1; p.src2_loaded = 1'b1;
    p.rd = 5'd10; p.rd_enable = 1'b1; p.need_rename = 1'b1; p.rd_phy = 6'd5;
    p.op = 4'd6; p.op_unit = 3'd2; p.checkpoint_id = 3'd1;
    p.src1_value = a; p.src2_value = b; p.sub_op.mul_op = op;
    return p;
  endfunction

  task automatic drive(input issue_execute_pack_t in, input logic vld,
                       input commit_feedback_pack_t c, input logic run);
    @(posedge clk);
    #1;
    io.issue_mul_fifo_data_out       = in;
    io.issue_mul_fifo_data_out_valid = vld;
    io.commit_feedback_pack          = c;
    sb.push_back(model(in, vld, c, run));
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    commit_feedback_pack_t c;
    c = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    drive(mk(MUL_MUL, 32'd7, 32'hFFFF_FFFD), 1'b1, c, 1'b0);
    e = sb.pop_front();
    checks++; if (io.issue_mul_fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %0b exp 0", io.issue_mul_fifo_pop); end
    checks++; if (io.mul_wb_port_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", io.mul_wb_port_we); end
    checks++; if (io.mul_wb_port_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b exp 0", io.mul_wb_port_flush); end
    checks++; if (io.mul_wb_port_data_in !== e.wb) begin errors++; $display("FAIL reset_wb: got %h exp %h", io.mul_wb_port_data_in, e.wb); end
    checks++; if (io.mul_execute_channel_feedback_pack !== e.fb) begin errors++; $display("FAIL reset_fb: got %h exp %h", io.mul_execute_channel_feedback_pack, e.fb); end
    rst = 1'b1;
  endtask

  task automatic test_mul_basic();
    exp_t e;
    commit_feedback_pack_t c;
    c = '0;
    drive(mk(MUL_MUL, 32'h0000_0007, 32'hFFFF_FFFD), 1'b1, c, 1'b1);
    e = sb.pop_front();
    checks++; if ({io.issue_mul_fifo_pop, io.mul_wb_port_we} !== 2'b11) begin errors++; $display("FAIL basic_pop_we: got %b exp 11", {io.issue_mul_fifo_pop, io.mul_wb_port_we}); end
    checks++; if (io.mul_wb_port_data_in.rd_value !== 32'hFFFF_FFEB) begin errors++; $display("FAIL basic_rd_value: got %h exp ffffffeb", io.mul_wb_port_data_in.rd_value); end
    checks++; if (io.mul_execute_channel_feedback_pack !== {1'b1, 6'd5, 32'hFFFF_FFEB}) begin errors++; $display("FAIL basic_fb: got %h exp %h", io.mul_execute_channel_feedback_pack, {1'b1, 6'd5, 32'hFFFF_FFEB}); end
    checks++; if (io.mul_wb_port_data_in !== e.wb) begin errors++; $display("FAIL basic_wb: got %h exp %h", io.mul_wb_port_data_in, e.wb); end
  endtask

  task automatic test_mul_variants();
    exp_t        e;
    commit_feedback_pack_t c;
    mul_op_t     ops[4];
    logic [31:0] lit[4];
    c = '0;
    ops[0] = MUL_MULH;   lit[0] = 32'h0000_0000;
    ops[1] = MUL_MULHU;  lit[1] = 32'h7FFF_FFFF;
    ops[2] = MUL_MULHSU; lit[2] = 32'h8000_0000;
    ops[3] = MUL_MUL;    lit[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      drive(mk(ops[i], 32'h8000_0000, 32'hFFFF_FFFF), 1'b1, c, 1'b1);
      e = sb.pop_front();
      checks++; if (io.mul_wb_port_data_in.rd_value !== lit[i]) begin errors++; $display("FAIL variant_%0d_rd_value: got %h exp %h", i, io.mul_wb_port_data_in.rd_value, lit[i]); end
      checks++; if (io.mul_execute_channel_feedback_pack !== e.fb) begin errors++; $display("FAIL variant_%0d_fb: got %h exp %h", i, io.mul_execute_channel_feedback_pack, e.fb); end
    end
  endtask

  task automatic test_exception();
    exp_t e;
    commit_feedback_pack_t c;
    issue_execute_pack_t in;
    c = '0;
    in = mk(MUL_MUL, 32'd9, 32'd9);
    in.has_exception = 1'b1;
    in.exception_id = 4'd2;
    in.exception_value = 32'h0000_1234;
    drive(in, 1'b1, c, 1'b1);
    e = sb.pop_front();
    checks++; if ({io.issue_mul_fifo_pop, io.mul_wb_port_we} !== 2'b11) begin errors++; $display("FAIL exc_pop_we: got %b exp 11", {io.issue_mul_fifo_pop, io.mul_wb_port_we}); end
    checks++; if (io.mul_wb_port_data_in.has_exception !== 1'b1 || io.mul_wb_port_data_in.exception_value !== 32'h1234) begin errors++; $display("FAIL exc_fields: got %b/%h exp 1/00001234", io.mul_wb_port_data_in.has_exception, io.mul_wb_port_data_in.exception_value); end
    checks++; if (io.mul_wb_port_data_in.rd_value !== 32'h0) begin errors++; $display("FAIL exc_rd_value: got %h exp 0", io.mul_wb_port_data_in.rd_value); end
    checks++; if (io.mul_execute_channel_feedback_pack.enable !== 1'b0) begin errors++; $display("FAIL exc_fb_enable: got %b exp 0", io.mul_execute_channel_feedback_pack.enable); end
    checks++; if (io.mul_wb_port_data_in !== e.wb) begin errors++; $display("FAIL exc_wb: got %h exp %h", io.mul_wb_port_data_in, e.wb); end
    in = mk(MUL_MUL, 32'd9, 32'd9);
    in.valid = 1'b0;
    drive(in, 1'b1, c, 1'b1);
    e = sb.pop_front();
    checks++; if (io.mul_wb_port_we !== 1'b1 || io.mul_wb_port_data_in.rd_value !== 32'h0) begin errors++; $display("FAIL invalid_wb: got we=%b rd=%h exp we=1 rd=0", io.mul_wb_port_we, io.mul_wb_port_data_in.rd_value); end
    checks++; if (io.mul_execute_channel_feedback_pack !== e.fb) begin errors++; $display("FAIL invalid_fb: got %h exp %h", io.mul_execute_channel_feedback_pack, e.fb); end
  endtask

  task automatic test_flush();
    exp_t e;
    commit_feedback_pack_t c;
    c.enable = 1'b1;
    c.flush  = 1'b1;
    drive(mk(MUL_MUL, 32'd3, 32'd4), 1'b1, c, 1'b1);
    e = sb.pop_front();
    checks++; if (io.mul_wb_port_flush !== 1'b1) begin errors++; $display("FAIL flush_out: got %0b exp 1", io.mul_wb_port_flush); end
    checks++; if ({io.issue_mul_fifo_pop, io.mul_wb_port_we} !== 2'b00) begin errors++; $display("FAIL flush_pop_we: got %b exp 00", {io.issue_mul_fifo_pop, io.mul_wb_port_we}); end
    checks++; if (io.mul_execute_channel_feedback_pack.enable !== 1'b0) begin errors++; $display("FAIL flush_fb_enable: got %b exp 0", io.mul_execute_channel_feedback_pack.enable); end
    checks++; if (io.mul_wb_port_data_in !== e.wb) begin errors++; $display("FAIL flush_wb: got %h exp %h", io.mul_wb_port_data_in, e.wb); end
    c.enable = 1'b0;
    drive(mk(MUL_MUL, 32'd3, 32'd4), 1'b1, c, 1'b1);
    e = sb.pop_front();
    checks++; if (io.mul_wb_port_flush !== 1'b0 || io.mul_wb_port_we !== 1'b1) begin errors++; $display("FAIL noflush_ctrl: got flush=%b we=%b exp flush=0 we=1", io.mul_wb_port_flush, io.mul_wb_port_we); end
    checks++; if (io.mul_wb_port_data_in.rd_value !== 32'd12) begin errors++; $display("FAIL noflush_rd_value: got %h exp 0000000c", io.mul_wb_port_data_in.rd_value); end
  endtask

  task automatic test_empty_and_no_rd();
    exp_t e;
    commit_feedback_pack_t c;
    issue_execute_pack_t in;
    c = '0;
    drive(mk(MUL_MUL, 32'd5, 32'd6), 1'b0, c, 1'b1);
    e = sb.pop_front();
    checks++; if ({io.issue_mul_fifo_pop, io.mul_wb_port_we, io.mul_wb_port_data_in.enable} !== 3'b000) begin errors++; $display("FAIL empty_ctrl: got %b exp 000", {io.issue_mul_fifo_pop, io.mul_wb_port_we, io.mul_wb_port_data_in.enable}); end
    checks++; if (io.mul_execute_channel_feedback_pack !== e.fb) begin errors++; $display("FAIL empty_fb: got %h exp %h", io.mul_execute_channel_feedback_pack, e.fb); end
    in = mk(MUL_MUL, 32'd5, 32'd6);
    in.rd_enable = 1'b0;
    drive(in, 1'b1, c, 1'b1);
    e = sb.pop_front();
    checks++; if (io.mul_wb_port_we !== 1'b1 || io.mul_wb_port_data_in.rd_value !== 32'd30) begin errors++; $display("FAIL nord_wb: got we=%b rd=%h exp we=1 rd=0000001e", io.mul_wb_port_we, io.mul_wb_port_data_in.rd_value); end
    checks++; if (io.mul_execute_channel_feedback_pack.enable !== 1'b0) begin errors++; $display("FAIL nord_fb_enable: got %b exp 0", io.mul_execute_channel_feedback_pack.enable); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    commit_feedback_pack_t c;
    issue_execute_pack_t in;
    logic [$bits(issue_execute_pack_t)-1:0] raw;
    logic vld;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < $bits(raw); i++) raw[i] = 1'($urandom_range(0, 1));
      in = raw;
      in.enable        = ($urandom_range(0, 7) != 0);
      in.valid         = ($urandom_range(0, 7) != 0);
      in.has_exception = ($urandom_range(0, 5) == 0);
      in.rd_enable     = ($urandom_range(0, 5) != 0);
      in.need_rename   = ($urandom_range(0, 5) != 0);
      vld      = ($urandom_range(0, 7) != 0);
      c.enable = ($urandom_range(0, 3) == 0);
      c.flush  = ($urandom_range(0, 1) == 0);
      drive(in, vld, c, 1'b1);
      e = sb.pop_front();
      checks++; if ({io.issue_mul_fifo_pop, io.mul_wb_port_we, io.mul_wb_port_flush} !== {e.pop, e.we, e.flush}) begin errors++; $display("FAIL b2b_%0d_ctrl: got %b exp %b", n, {io.issue_mul_fifo_pop, io.mul_wb_port_we, io.mul_wb_port_flush}, {e.pop, e.we, e.flush}); end
      checks++; if (io.mul_wb_port_data_in !== e.wb) begin errors++; $display("FAIL b2b_%0d_wb: got %h exp %h", n, io.mul_wb_port_data_in, e.wb); end
      checks++; if (io.mul_execute_channel_feedback_pack !== e.fb) begin errors++; $display("FAIL b2b_%0d_fb: got %h exp %h", n, io.mul_execute_channel_feedback_pack, e.fb); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    io.issue_mul_fifo_data_out       = '0;
    io.issue_mul_fifo_data_out_valid = 1'b0;
    io.commit_feedback_pack          = '0;
    test_reset();
    test_mul_basic();
    test_mul_variants();
    test_exception();
    test_flush();
    test_empty_and_no_rd();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_mul_unit.md
Name: execute_mul_unit

Overview:
- Single-cycle integer multiply execute unit of the out-of-order core; one instance per MUL unit (count set by `MUL_UNIT_NUM`).
- Takes one issue_execute_pack_t from the issue→mul FIFO and computes the RV32M multiply result.
- Drives an execute_wb_pack_t into the writeback port and broadcasts the result on the execute feedback (bypass/wakeup) channel.
- Datapath is purely combinational; the only clocked aspect is reset gating.

Parameters:
- None. All widths come from common.svh / config.svh: PHY_REG_ID_WIDTH, ROB_ID_WIDTH, CHECKPOINT_ID_WIDTH, 32-bit data.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-low.
- issue_mul_fifo_data_out  in  issue_execute_pack_t  head entry of the issue→mul FIFO.
- issue_mul_fifo_data_out_valid  in  1  FIFO head valid (FIFO not empty).
- issue_mul_fifo_pop  out  1  consume FIFO head this cycle.
- mul_wb_port_data_in  out  execute_wb_pack_t  packet to the writeback port.
- mul_wb_port_we  out  1  writeback port write enable.
- mul_wb_port_flush  out  1  writeback port flush.
- mul_execute_channel_feedback_pack  out  execute_feedback_channel_t  fields: enable, phy_id, value.
- commit_feedback_pack  in  commit_feedback_pack_t  only .enable and .flush are used.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst).
- Definitions:
  - flush = commit_feedback_pack.enable & commit_feedback_pack.flush.
  - go = rst high & issue_mul_fifo_data_out_valid & !flush.
  - in = issue_mul_fifo_data_out.
  - Sampled value = the registered version of rst.
- Reset (rst low): all outputs 0, including pack fields and mul_wb_port_flush. Outputs are evaluated combinationally from current inputs; no pipeline state.
- Handshake: the writeback port always accepts, so there is no stall.
  - issue_mul_fifo_pop = go.
  - mul_wb_port_we = go.
  - Empty FIFO → pop=0, we=0, wb enable=0.
- Flush: mul_wb_port_flush = flush (and rst high). While flushing, pop=0, we=0, wb enable=0, feedback enable=0.
- Writeback packet when go:
  - enable = in.enable.
  - Copied unchanged from in: value, valid, rob_id, pc, imm, has_exception, exception_id, exception_value, predicted, predicted_jump, predicted_next_pc, checkpoint_id_valid, checkpoint_id, rs1, arg1_src, rs1_need_map, rs1_phy, src1_value, src1_loaded, rs2, arg2_src, rs2_need_map, rs2_phy, src2_value, src2_loaded, rd, rd_enable, need_rename, rd_phy, csr, op, op_unit, sub_op.
  - Forced to 0: bru_jump, bru_next_pc, csr_newvalue_valid, csr_newvalue.
  - When not go, the whole packet is 0.
- rd_value: computed when in.enable & in.valid & !in.has_exception, otherwise 0. With a=src1_value, b=src2_value, selected by sub_op.mul_op:
  - mul: low 32 bits of a*b.
  - mulh: high 32 bits of signed(a) × signed(b).
  - mulhsu: high 32 bits of signed(a) × unsigned(b).
  - mulhu: high 32 bits of unsigned(a) × unsigned(b).
  - Implement as one 33×33 signed multiply with per-operand sign extension. The 64-bit product is exact; no overflow or saturation.
- Feedback:
  - enable = go & in.enable & in.valid & !in.has_exception & in.rd_enable & in.need_rename.
  - When enabled: phy_id = rd_phy, value = rd_value.
  - When not enabled: phy_id = 0, value = 0.
- Invalid or exception entries (valid=0 or has_exception=1) are still popped and written back with rd_value = 0, so the ROB sees the exception. They produce no feedback.
- Back-to-back: a new FIFO head each cycle is consumed at a rate of one instruction per cycle.

Test Plan:
- rst low, FIFO valid=1 → pop=0, we=0, flush=0, wb enable=0, feedback all 0. Release rst → normal operation from the next evaluation.
- mul, src1=0x00000007, src2=0xFFFFFFFD, rd_enable=1, need_rename=1, rd_phy=5, valid=1 → pop=1, we=1, rd_value=0xFFFFFFEB, feedback {1, 5, 0xFFFFFFEB}.
- a=0x80000000, b=0xFFFFFFFF:
  - mulh → 0x00000000.
  - mulhu → 0x7FFFFFFF.
  - mulhsu → 0x80000000.
  - mul → 0x80000000.
- valid=1, has_exception=1, exception_value=0x1234 → pop=1, we=1, wb has_exception=1, exception_value=0x1234, rd_value=0, feedback enable=0.
- commit_feedback_pack.enable=1, flush=1 with FIFO valid → mul_wb_port_flush=1, pop=0, we=0, feedback enable=0. Same stimulus with enable=0 → no flush, normal writeback.
- FIFO valid=0 → pop=0, we=0, wb enable=0. rd_enable=0 with a valid mul → writeback occurs, feedback enable=0.
